// File: rtl/counter_bus_master.sv
// Host-side initiator for the counter peripheral strobe bus.
// It turns each valid/ready command into a timed csq/wrq/rdq sequence:
// SETUP -> STROBE -> HOLD -> RECOV, with every phase counted in sclk cycles.
module counter_bus_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned WR_STRB_CYC = 4,
  parameter int unsigned RD_STRB_CYC = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOV_CYC   = 1
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] abus,
  output logic       csq,
  output logic       wrq,
  output logic       rdq,
  output logic [7:0] dbus_o,
  output logic       dbus_oe,
  input  logic [7:0] dbus_i
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOV
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        op_write;

  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] WR_LD    = 16'(WR_STRB_CYC - 1);
  localparam logic [15:0] RD_LD    = 16'(RD_STRB_CYC - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] RECOV_LD = 16'(RECOV_CYC - 1);

  // Ready is decoded from state so a command can be accepted in any IDLE cycle.
  assign cmd_ready = (state == IDLE);

  // Phase sequencer: each output is set on the edge that enters the phase it belongs to,
  // so the bus pins stay registered and never see cmd_* combinationally.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      abus      <= '0;
      csq       <= 1'b1;
      wrq       <= 1'b1;
      rdq       <= 1'b1;
      dbus_o    <= '0;
      dbus_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_write <= cmd_write;
            abus     <= cmd_addr;
            csq      <= 1'b0;
            dbus_oe  <= cmd_write;
            if (cmd_write) dbus_o <= cmd_wdata;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            wrq   <= ~op_write;
            rdq   <= op_write;
            cnt   <= op_write ? WR_LD : RD_LD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            wrq   <= 1'b1;
            rdq   <= 1'b1;
            cnt   <= HOLD_LD;
            state <= HOLD;
            // Capture happens while rdq is still low; the pulse then marks the first HOLD cycle.
            if (!op_write) begin
              rsp_rdata <= dbus_i;
              rsp_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            csq     <= 1'b1;
            dbus_oe <= 1'b0;
            cnt     <= RECOV_LD;
            state   <= RECOV;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RECOV: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_bus_master.sv
// Bench for counter_bus_master: a default-timing instance talking to a small
// register-file peripheral, plus a minimum-timing instance for the fast corner.
module tb_counter_bus_master;

  localparam int unsigned S  = 2;
  localparam int unsigned TW = 4;
  localparam int unsigned TR = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned R  = 1;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] abus;
  logic       csq, wrq, rdq, dbus_oe;
  logic [7:0] dbus_o, dbus_i;

  logic       f_cmd_valid = 1'b0, f_cmd_ready, f_cmd_write = 1'b0;
  logic [1:0] f_cmd_addr = '0;
  logic [7:0] f_cmd_wdata = '0;
  logic       f_rsp_valid;
  logic [7:0] f_rsp_rdata;
  logic [1:0] f_abus;
  logic       f_csq, f_wrq, f_rdq, f_dbus_oe;
  logic [7:0] f_dbus_o, f_dbus_i;

  int checks = 0;
  int fails  = 0;

  always #5 sclk = ~sclk;

  counter_bus_master #(
    .SETUP_CYC(S), .WR_STRB_CYC(TW), .RD_STRB_CYC(TR), .HOLD_CYC(H), .RECOV_CYC(R)
  ) dut (
    .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .abus(abus), .csq(csq),
    .wrq(wrq), .rdq(rdq), .dbus_o(dbus_o), .dbus_oe(dbus_oe), .dbus_i(dbus_i)
  );

  counter_bus_master #(
    .SETUP_CYC(1), .WR_STRB_CYC(1), .RD_STRB_CYC(1), .HOLD_CYC(1), .RECOV_CYC(1)
  ) dut_fast (
    .sclk(sclk), .rst(rst), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_write(f_cmd_write), .cmd_addr(f_cmd_addr), .cmd_wdata(f_cmd_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .abus(f_abus), .csq(f_csq),
    .wrq(f_wrq), .rdq(f_rdq), .dbus_o(f_dbus_o), .dbus_oe(f_dbus_oe), .dbus_i(f_dbus_i)
  );

  // Peripheral: four registers, latched on the wrq rising edge, driven only while read-selected.
  logic [7:0] periph  [4] = '{8'h11, 8'hA7, 8'h00, 8'h6E};
  logic [7:0] ref_mem [4] = '{8'h11, 8'hA7, 8'h00, 8'h6E};
  logic [7:0] junk = 8'h00;

  always @(posedge sclk) junk <= 8'($urandom);
  always @(posedge wrq) if (!rst && !csq && dbus_oe) periph[abus] <= dbus_o;
  assign dbus_i   = (!csq && !rdq) ? periph[abus] : junk;
  assign f_dbus_i = (!f_csq && !f_rdq) ? 8'hC3 : 8'h00;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Bus-level safety rules, checked every cycle on both instances.
  always @(negedge sclk) begin
    if (!rst) begin
      chk("no_strobe_overlap", 32'(!(!wrq && !rdq)), 1);
      chk("strobe_needs_cs", 32'(!((!wrq || !rdq) && csq)), 1);
      chk("no_oe_on_read", 32'(!(dbus_oe && !rdq)), 1);
      chk("f_no_strobe_overlap", 32'(!(!f_wrq && !f_rdq)), 1);
      chk("f_no_oe_on_read", 32'(!(f_dbus_oe && !f_rdq)), 1);
    end
  end

  // Issue one command (called at a negedge) and check every cycle from accept until ready returns.
  task automatic run_cmd(input bit w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    int unsigned strb;
    int unsigned last;
    int n;
    strb = w ? TW : TR;
    last = S + strb + H + R;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin
      @(negedge sclk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge sclk);
    for (int unsigned k = 1; k <= last + 1; k++) begin
      @(negedge sclk);
      chk("csq", 32'(csq), (k <= S + strb + H) ? 0 : 1);
      chk("wrq", 32'(wrq), (w && k > S && k <= S + strb) ? 0 : 1);
      chk("rdq", 32'(rdq), (!w && k > S && k <= S + strb) ? 0 : 1);
      chk("dbus_oe", 32'(dbus_oe), (w && k <= S + strb + H) ? 1 : 0);
      if (w && k <= S + strb + H) chk("dbus_o", 32'(dbus_o), 32'(d));
      chk("abus", 32'(abus), 32'(a));
      chk("rsp_valid", 32'(rsp_valid), (!w && k == S + strb + 1) ? 1 : 0);
      if (!w && k >= S + strb + 1) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      chk("cmd_ready", 32'(cmd_ready), (k == last + 1) ? 1 : 0);
      if (k < last) begin
        cmd_write = 1'($urandom);
        cmd_addr  = 2'($urandom);
        cmd_wdata = 8'($urandom);
      end
    end
  endtask

  typedef struct {
    bit         write;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 2'd2, 8'h05, 8'h00};
    vecs[1] = '{1'b0, 2'd1, 8'h00, 8'hA7};
    vecs[2] = '{1'b0, 2'd2, 8'h00, 8'h05};
    vecs[3] = '{1'b1, 2'd0, 8'h03, 8'h00};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 8'h03};
    vecs[5] = '{1'b0, 2'd3, 8'h00, 8'h6E};
    vecs[6] = '{1'b1, 2'd3, 8'hFF, 8'h00};
    vecs[7] = '{1'b0, 2'd3, 8'h00, 8'hFF};
    vecs[8] = '{1'b1, 2'd1, 8'h5A, 8'h00};
    vecs[9] = '{1'b0, 2'd1, 8'h00, 8'h5A};

    // Reset values.
    repeat (3) @(negedge sclk);
    chk("rst_csq", 32'(csq), 1);
    chk("rst_wrq", 32'(wrq), 1);
    chk("rst_rdq", 32'(rdq), 1);
    chk("rst_oe", 32'(dbus_oe), 0);
    chk("rst_abus", 32'(abus), 0);
    chk("rst_dbus_o", 32'(dbus_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    rst = 1'b0;
    @(negedge sclk);
    chk("idle_ready", 32'(cmd_ready), 1);

    // Minimum timing: read completes in four cycles, rdq low for one.
    f_cmd_valid = 1'b1; f_cmd_write = 1'b0; f_cmd_addr = 2'd3;
    @(posedge sclk);
    #1 f_cmd_valid = 1'b0;
    for (int unsigned k = 1; k <= 5; k++) begin
      @(negedge sclk);
      chk("f_rdq", 32'(f_rdq), (k == 2) ? 0 : 1);
      chk("f_csq", 32'(f_csq), (k <= 3) ? 0 : 1);
      chk("f_oe", 32'(f_dbus_oe), 0);
      chk("f_rsp_valid", 32'(f_rsp_valid), (k == 3) ? 1 : 0);
      if (k >= 3) chk("f_rsp_rdata", 32'(f_rsp_rdata), 32'h0C3);
      chk("f_cmd_ready", 32'(f_cmd_ready), (k == 5) ? 1 : 0);
    end

    // Directed table, issued back to back with cmd_valid held high.
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
      if (vecs[i].write) ref_mem[vecs[i].addr] = vecs[i].wdata;
    end

    // Random traffic against the register-file reference.
    for (int i = 0; i < 40; i++) begin
      bit         w;
      logic [1:0] a;
      logic [7:0] d;
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom);
      d = 8'($urandom);
      run_cmd(w, a, d, ref_mem[a]);
      if (w) ref_mem[a] = d;
    end
    cmd_valid = 1'b0;

    // Reset in the middle of a write strobe.
    @(negedge sclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = ~ref_mem[1];
    @(posedge sclk);
    #1 cmd_valid = 1'b0;
    repeat (S + 2) @(negedge sclk);
    chk("pre_rst_wrq", 32'(wrq), 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_wrq", 32'(wrq), 1);
    chk("arst_csq", 32'(csq), 1);
    chk("arst_oe", 32'(dbus_oe), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    chk("arst_rsp_rdata", 32'(rsp_rdata), 0);
    repeat (2) begin
      @(negedge sclk);
      chk("arst_rsp_valid", 32'(rsp_valid), 0);
    end
    rst = 1'b0;
    @(negedge sclk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    run_cmd(1'b0, 2'd1, 8'h00, ref_mem[1]);
    cmd_valid = 1'b0;
    repeat (2) @(negedge sclk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d fails=%0d", checks, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
